// File: rtl/ser_link_pkg.sv
// Shared definitions for the serial word link (PISO transmitter and
// serial word receiver): receiver FSM states and the default word width.
package ser_link_pkg;

    localparam int DEFAULT_WORD_W = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/serial_word_receiver_if.sv
// Bundle of the serial receiver's link, check and handshake signals.
// slave: receiver side (sin/cs/expected/dout_ready in, word + status out).
// master: driver/consumer side (mirror image of slave).
interface serial_word_receiver_if #(
    parameter int WIDTH = 4
);

    logic             sin;
    logic             cs;
    logic [WIDTH-1:0] expected;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             match;
    logic             frame_err;
    logic             overrun;
    logic             busy;

    modport slave (
        input  sin,
        input  cs,
        input  expected,
        input  dout_ready,
        output dout,
        output dout_valid,
        output match,
        output frame_err,
        output overrun,
        output busy
    );

    modport master (
        output sin,
        output cs,
        output expected,
        output dout_ready,
        input  dout,
        input  dout_valid,
        input  match,
        input  frame_err,
        input  overrun,
        input  busy
    );

endinterface

// File: rtl/ser_shift_in.sv
// Serial-in shift register plus bit counter for the word receiver.
// Ports: clk, rst_n (sync, active low), sin/cs (serial link in);
// word (assembled word incl. current bit), word_done (last bit sampled
// this edge), mid_word_abort (cs low with a partial word held).
module ser_shift_in #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             cs,
    output logic [WIDTH-1:0] word,
    output logic             word_done,
    output logic             mid_word_abort
);

    localparam int CW = $clog2(WIDTH + 1);

    // Only the WIDTH-1 earlier bits need storing; the current bit
    // comes straight from sin when the word completes.
    logic [WIDTH-2:0] shift_q;
    logic [WIDTH-2:0] shift_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-2:0] shifted;

    generate
        if (MSB_FIRST) begin : g_msb
            assign word    = {shift_q, sin};
            assign shifted = word[WIDTH-2:0];
        end else begin : g_lsb
            assign word    = {sin, shift_q};
            assign shifted = word[WIDTH-1:1];
        end
    endgenerate

    assign word_done      = cs && (cnt_q == CW'(WIDTH - 1));
    assign mid_word_abort = !cs && (cnt_q != '0);

    always_comb begin
        shift_d = '0;
        cnt_d   = '0;
        // Completion and abort both clear the register so a later
        // word starts from a clean slate.
        if (cs && !word_done) begin
            shift_d = shifted;
            cnt_d   = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial word receiver: assembles cs-framed serial bits into words,
// offers them on a valid/ready output and self-checks each word.
// Ports: clk, rst_n (sync, active low), bus (slave modport: sin, cs,
// expected, dout_ready in; dout, dout_valid, match, frame_err,
// overrun, busy out). All outputs are registered.
module serial_word_receiver
    import ser_link_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WORD_W,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_word_receiver_if.slave bus
);

    logic [WIDTH-1:0] word;
    logic             word_done;
    logic             mid_word_abort;

    ser_shift_in #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift_in (
        .clk            (clk),
        .rst_n          (rst_n),
        .sin            (bus.sin),
        .cs             (bus.cs),
        .word           (word),
        .word_done      (word_done),
        .mid_word_abort (mid_word_abort)
    );

    rx_state_t        state_q;
    rx_state_t        state_d;
    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic             valid_q;
    logic             valid_d;
    logic             match_q;
    logic             match_d;
    logic             frame_err_q;
    logic             frame_err_d;
    logic             overrun_q;
    logic             overrun_d;
    logic             busy_q;
    logic             busy_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.cs) state_d = SHIFT;
            SHIFT:   if (!bus.cs || word_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dout_d      = dout_q;
        valid_d     = valid_q;
        match_d     = match_q;
        overrun_d   = 1'b0;
        frame_err_d = mid_word_abort;
        busy_d      = (state_d == SHIFT);

        if (word_done) begin
            // A held word that is consumed this cycle frees the slot
            // for the word completing on the same edge.
            if (!valid_q || bus.dout_ready) begin
                dout_d  = word;
                valid_d = 1'b1;
                match_d = (word == bus.expected);
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && bus.dout_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            match_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            match_q     <= match_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = valid_q;
    assign bus.match      = match_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
    assign bus.busy       = busy_q;

endmodule

// File: doc/serial_word_receiver.md
Name: serial_word_receiver

Overview:
- Receive end of the 4-bit PISO serial link: samples a serial bitstream qualified by chip-select, assembles WIDTH-bit words, presents each word on a parallel output under a valid/ready handshake.
- Built-in self-check compares each completed word against an expected word. This replaces the separate serial validator used on the transmit side.
- Sits directly after the PISO register, or after any serializer using the same cs/sin framing.

Parameters:
- WIDTH, 4, word length in bits (>= 2).
- MSB_FIRST, 1, 1 = first received bit is dout[WIDTH-1]; 0 = first bit is dout[0].

Ports:
- clk  input  1  rising-edge clock, shared with the transmitter.
- rst_n  input  1  synchronous active-low reset.
- sin  input  1  serial data bit.
- cs  input  1  chip select; sin is sampled on every rising edge where cs=1.
- expected  input  WIDTH  reference word for the self-check.
- dout  output  WIDTH  last completed word (holding register).
- dout_valid  output  1  dout holds an unconsumed word.
- dout_ready  input  1  consumer accepts dout when dout_valid=1.
- match  output  1  the word in dout equalled expected at its completion edge.
- frame_err  output  1  one-cycle pulse: cs fell mid-word.
- overrun  output  1  one-cycle pulse: a completed word was dropped.
- busy  output  1  a partial word is in progress (bit count != 0).

Behaviour:
- Reset (rst_n=0 at a rising edge) has priority over all other inputs:
  - outputs: dout=0, dout_valid=0, match=0, frame_err=0, overrun=0, busy=0;
  - internal state: shift register=0, bit counter=0, FSM=IDLE.
- Reset asserted mid-word discards the partial word with no frame_err.
- FSM states:
  - IDLE (count=0): cs=1 samples the first bit, count becomes 1, go to SHIFT.
  - SHIFT (0<count<WIDTH): cs=1 samples a bit and increments count.
- Word completion: when the WIDTH-th bit is sampled, count returns to 0 and the FSM goes to IDLE at that same edge.
- Back-to-back words: cs held high continuously yields consecutive words with no gap cycle.
- Bit counter width: $clog2(WIDTH+1).
- Assembly:
  - MSB_FIRST=1: shift left, new bit enters at the LSB.
  - MSB_FIRST=0: shift right, new bit enters at the MSB.
- Word load at completion:
  - Taken from the assembled word including the current bit.
  - If dout_valid=0, or dout_valid=1 with dout_ready=1 in the same cycle: dout<=word, dout_valid<=1, match<=(word==expected).
  - Otherwise (dout_valid=1, dout_ready=0): the new word is dropped; dout, dout_valid and match are unchanged; overrun pulses for one cycle.
- Latency: last bit sampled at edge N; dout/dout_valid/match are valid from edge N through at least one cycle.
- Handshake:
  - dout_valid stays 1 until a cycle with dout_ready=1. If no completion occurs in that cycle, dout_valid<=0.
  - dout and match are held stable while dout_valid=1.
  - dout_ready while dout_valid=0 has no effect.
- Frame error: cs=0 at an edge while in SHIFT:
  - frame_err pulses for one cycle;
  - count<=0, FSM goes to IDLE, the partial word is discarded;
  - dout and the handshake are unaffected.
- cs=0 in IDLE is a no-op.
- busy = (state==SHIFT), registered.
- No combinational paths from inputs to outputs.

Decomposition:
- Shared package ser_link_pkg:
  - state enum rx_state_t {IDLE, SHIFT};
  - constant DEFAULT_WORD_W=4.
  - The same package is to be reused by the PISO transmitter.
- One natural sub-module: ser_shift_in. It holds the shift register plus bit counter and exposes word, word_done and mid_word_abort.
- The top level holds the FSM, output register, handshake and check logic.

Test Plan:
- WIDTH=4, MSB_FIRST=1, expected=4'hD, dout_ready=1: send bits 1,1,0,1 with cs=1 -> dout=4'hD, dout_valid=1 and match=1 after the 4th edge; dout_valid=0 one cycle later.
- Same setup, expected=4'h2, cs high for 8 bits 1101 then 0010 back-to-back -> dout=4'hD with match=0, then dout=4'h2 with match=1, exactly 4 cycles apart; frame_err never asserts.
- dout_ready=0: send 4'hD then 4'h3 -> dout stays 4'hD, dout_valid=1, one-cycle overrun on the 8th edge. Then raise dout_ready -> dout_valid=0 next cycle.
- dout_valid=1 with dout_ready=1 exactly on the completion edge of 4'h3 -> dout=4'h3, dout_valid stays 1, no overrun.
- cs drops after 2 bits -> one-cycle frame_err, busy=0. A following 4-bit frame 1010 -> dout=4'hA (old partial bits do not leak).
- rst_n=0 for one cycle after 3 bits -> all outputs 0, no frame_err. Then MSB_FIRST=0 instance sends 1,0,0,0 -> dout=4'h1.
